id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage_pkg.sv | 73 +++++++
 rtl/id_ex_stage_if.sv | 62 ++++++
 rtl/id_ex_stage_hazard_unit.sv | 43 ++++
 rtl/id_ex_stage.sv | 86 ++++++++
 tb/tb_id_ex_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX stage: ALU control codes, operand-select encodings,
// forward selects and the ID/EX register set.
package id_ex_stage_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9,
        ALU_EQ   = 4'hA,
        ALU_NE   = 4'hB,
        ALU_LT   = 4'hC,
        ALU_GE   = 4'hD,
        ALU_LTU  = 4'hE,
        ALU_GEU  = 4'hF
    } alu_ctrl_e;

    localparam logic OP1_RS1 = 1'b0;
    localparam logic OP1_PC  = 1'b1;
    localparam logic OP2_RS2 = 1'b0;
    localparam logic OP2_IMM = 1'b1;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd_addr;
        logic [XLEN-1:0]   imm;
        alu_ctrl_e         alu_ctrl;
        logic              op1_sel;
        logic              op2_sel;
        logic              reg_wr;
        logic              mem_rd;
        logic              mem_wr;
        logic              valid;
    } id_ex_t;

    // x0 is hardwired to zero, so a write to it is never a forward source.
    function automatic logic fwd_hit(input logic reg_wr,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
        return reg_wr && (rd != '0) && (rd == rs);
    endfunction

    function automatic logic [XLEN-1:0] fwd_value(input fwd_sel_e sel,
                                                  input logic [XLEN-1:0] stored,
                                                  input logic [XLEN-1:0] exmem,
                                                  input logic [XLEN-1:0] memwb);
        case (sel)
            FWD_EXMEM: return exmem;
            FWD_MEMWB: return memwb;
            default:   return stored;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decoder/forwarding-side bundle of the ID/EX stage; the stage uses the slave
// modport, whoever drives the decoder and forward sources uses master.
interface id_ex_stage_if;
    import id_ex_stage_pkg::*;

    logic              i_valid;
    logic [XLEN-1:0]   i_pc;
    logic [XLEN-1:0]   i_rs1_data;
    logic [XLEN-1:0]   i_rs2_data;
    logic [REG_AW-1:0] i_rs1_addr;
    logic [REG_AW-1:0] i_rs2_addr;
    logic [REG_AW-1:0] i_rd_addr;
    logic [XLEN-1:0]   i_imm;
    alu_ctrl_e         i_alu_ctrl;
    logic              i_op1_sel;
    logic              i_op2_sel;
    logic              i_reg_wr;
    logic              i_mem_rd;
    logic              i_mem_wr;
    logic              i_flush;
    logic              i_stall;
    logic [REG_AW-1:0] i_exmem_rd;
    logic              i_exmem_reg_wr;
    logic [XLEN-1:0]   i_exmem_result;
    logic [REG_AW-1:0] i_memwb_rd;
    logic              i_memwb_reg_wr;
    logic [XLEN-1:0]   i_memwb_result;

    logic [XLEN-1:0]   o_op1;
    logic [XLEN-1:0]   o_op2;
    alu_ctrl_e         o_alu_ctrl;
    logic              o_alu_stall;
    logic [XLEN-1:0]   o_store_data;
    logic [XLEN-1:0]   o_pc;
    logic              o_valid;
    logic              o_reg_wr;
    logic              o_mem_rd;
    logic              o_mem_wr;
    logic [REG_AW-1:0] o_rd_addr;
    logic              o_id_stall;

    modport master (
        output i_valid, i_pc, i_rs1_data, i_rs2_data, i_rs1_addr, i_rs2_addr,
               i_rd_addr, i_imm, i_alu_ctrl, i_op1_sel, i_op2_sel, i_reg_wr,
               i_mem_rd, i_mem_wr, i_flush, i_stall,
               i_exmem_rd, i_exmem_reg_wr, i_exmem_result,
               i_memwb_rd, i_memwb_reg_wr, i_memwb_result,
        input  o_op1, o_op2, o_alu_ctrl, o_alu_stall, o_store_data, o_pc,
               o_valid, o_reg_wr, o_mem_rd, o_mem_wr, o_rd_addr, o_id_stall
    );

    modport slave (
        input  i_valid, i_pc, i_rs1_data, i_rs2_data, i_rs1_addr, i_rs2_addr,
               i_rd_addr, i_imm, i_alu_ctrl, i_op1_sel, i_op2_sel, i_reg_wr,
               i_mem_rd, i_mem_wr, i_flush, i_stall,
               i_exmem_rd, i_exmem_reg_wr, i_exmem_result,
               i_memwb_rd, i_memwb_reg_wr, i_memwb_result,
        output o_op1, o_op2, o_alu_ctrl, o_alu_stall, o_store_data, o_pc,
               o_valid, o_reg_wr, o_mem_rd, o_mem_wr, o_rd_addr, o_id_stall
    );

endinterface

// File: rtl/id_ex_stage_hazard_unit.sv
// Combinational hazard logic: forward-select generation for the instruction
// held in ID/EX and load-use detection against the instruction in decode.
module hazard_unit
    import id_ex_stage_pkg::*;
(
    input  logic              st_valid,
    input  logic              st_mem_rd,
    input  logic [REG_AW-1:0] st_rd_addr,
    input  logic [REG_AW-1:0] st_rs1_addr,
    input  logic [REG_AW-1:0] st_rs2_addr,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rs1_addr,
    input  logic [REG_AW-1:0] dec_rs2_addr,
    input  logic              flush,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_wr,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_wr,
    output fwd_sel_e          fwd1_sel,
    output fwd_sel_e          fwd2_sel,
    output logic              load_use
);

    // The younger EX/MEM result wins over MEM/WB when both write the same register.
    always_comb begin
        fwd1_sel = FWD_NONE;
        fwd2_sel = FWD_NONE;
        if (fwd_hit(exmem_reg_wr, exmem_rd, st_rs1_addr))
            fwd1_sel = FWD_EXMEM;
        else if (fwd_hit(memwb_reg_wr, memwb_rd, st_rs1_addr))
            fwd1_sel = FWD_MEMWB;
        if (fwd_hit(exmem_reg_wr, exmem_rd, st_rs2_addr))
            fwd2_sel = FWD_EXMEM;
        else if (fwd_hit(memwb_reg_wr, memwb_rd, st_rs2_addr))
            fwd2_sel = FWD_MEMWB;
    end

    // Conservative: operand selects are ignored, any matching source stalls.
    assign load_use = dec_valid && st_valid && st_mem_rd && (st_rd_addr != '0) &&
                      ((st_rd_addr == dec_rs1_addr) || (st_rd_addr == dec_rs2_addr)) &&
                      !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB,
// load-use bubble insertion and flush/stall handling.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    id_ex_stage_if.slave bus
);

    id_ex_t            st;
    fwd_sel_e          fwd1_sel;
    fwd_sel_e          fwd2_sel;
    logic              load_use;
    logic [XLEN-1:0]   fwd_rs1;
    logic [XLEN-1:0]   fwd_rs2;

    hazard_unit u_hazard (
        .st_valid     (st.valid),
        .st_mem_rd    (st.mem_rd),
        .st_rd_addr   (st.rd_addr),
        .st_rs1_addr  (st.rs1_addr),
        .st_rs2_addr  (st.rs2_addr),
        .dec_valid    (bus.i_valid),
        .dec_rs1_addr (bus.i_rs1_addr),
        .dec_rs2_addr (bus.i_rs2_addr),
        .flush        (bus.i_flush),
        .exmem_rd     (bus.i_exmem_rd),
        .exmem_reg_wr (bus.i_exmem_reg_wr),
        .memwb_rd     (bus.i_memwb_rd),
        .memwb_reg_wr (bus.i_memwb_reg_wr),
        .fwd1_sel     (fwd1_sel),
        .fwd2_sel     (fwd2_sel),
        .load_use     (load_use)
    );

    assign fwd_rs1 = fwd_value(fwd1_sel, st.rs1_data, bus.i_exmem_result, bus.i_memwb_result);
    assign fwd_rs2 = fwd_value(fwd2_sel, st.rs2_data, bus.i_exmem_result, bus.i_memwb_result);

    // While held, forwarded values are written back so a producer retiring
    // during the hold is not lost once the forward source moves on.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_flush) begin
            st          <= '0;
            st.alu_ctrl <= ALU_ADD;
        end else if (bus.i_stall) begin
            if (fwd1_sel != FWD_NONE)
                st.rs1_data <= fwd_rs1;
            if (fwd2_sel != FWD_NONE)
                st.rs2_data <= fwd_rs2;
        end else if (load_use) begin
            st          <= '0;
            st.alu_ctrl <= ALU_ADD;
        end else begin
            st <= '{pc:       bus.i_pc,
                    rs1_data: bus.i_rs1_data,
                    rs2_data: bus.i_rs2_data,
                    rs1_addr: bus.i_rs1_addr,
                    rs2_addr: bus.i_rs2_addr,
                    rd_addr:  bus.i_rd_addr,
                    imm:      bus.i_imm,
                    alu_ctrl: bus.i_alu_ctrl,
                    op1_sel:  bus.i_op1_sel,
                    op2_sel:  bus.i_op2_sel,
                    reg_wr:   bus.i_reg_wr,
                    mem_rd:   bus.i_mem_rd,
                    mem_wr:   bus.i_mem_wr,
                    valid:    bus.i_valid};
        end
    end

    assign bus.o_op1        = (st.op1_sel == OP1_PC)  ? st.pc  : fwd_rs1;
    assign bus.o_op2        = (st.op2_sel == OP2_IMM) ? st.imm : fwd_rs2;
    assign bus.o_store_data = fwd_rs2;
    assign bus.o_alu_ctrl   = st.alu_ctrl;
    assign bus.o_alu_stall  = bus.i_stall | ~st.valid;
    assign bus.o_pc         = st.pc;
    assign bus.o_rd_addr    = st.rd_addr;
    assign bus.o_valid      = st.valid;
    assign bus.o_reg_wr     = st.reg_wr & st.valid;
    assign bus.o_mem_rd     = st.mem_rd & st.valid;
    assign bus.o_mem_wr     = st.mem_wr & st.valid;
    // Reset masks load-use so only the downstream hold leaks through.
    assign bus.o_id_stall   = bus.i_stall | (load_use & ~i_rst);

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding priority, load-use bubble,
// hold-time refresh, flush over stall and reset behaviour.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compare_count  = 0;
    int   mismatch_count = 0;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc,
                                 input logic [4:0] rs1, input logic [31:0] rs1_data,
                                 input logic [4:0] rs2, input logic [31:0] rs2_data,
                                 input logic [4:0] rd, input logic [31:0] imm,
                                 input alu_ctrl_e alu, input logic op1_sel, input logic op2_sel,
                                 input logic reg_wr, input logic mem_rd, input logic mem_wr);
        bus.i_valid    = v;
        bus.i_pc       = pc;
        bus.i_rs1_addr = rs1;
        bus.i_rs1_data = rs1_data;
        bus.i_rs2_addr = rs2;
        bus.i_rs2_data = rs2_data;
        bus.i_rd_addr  = rd;
        bus.i_imm      = imm;
        bus.i_alu_ctrl = alu;
        bus.i_op1_sel  = op1_sel;
        bus.i_op2_sel  = op2_sel;
        bus.i_reg_wr   = reg_wr;
        bus.i_mem_rd   = mem_rd;
        bus.i_mem_wr   = mem_wr;
    endtask

    task automatic setForward(input logic ex_wr, input logic [4:0] ex_rd, input logic [31:0] ex_res,
                              input logic wb_wr, input logic [4:0] wb_rd, input logic [31:0] wb_res);
        bus.i_exmem_reg_wr = ex_wr;
        bus.i_exmem_rd     = ex_rd;
        bus.i_exmem_result = ex_res;
        bus.i_memwb_reg_wr = wb_wr;
        bus.i_memwb_rd     = wb_rd;
        bus.i_memwb_result = wb_res;
    endtask

    initial begin
        applyStimulus(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        setForward(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        bus.i_flush = 1'b0;
        bus.i_stall = 1'b0;

        // Reset state
        tick();
        tick();
        checkOutput("rst_op1", bus.o_op1, 32'h0);
        checkOutput("rst_op2", bus.o_op2, 32'h0);
        checkOutput("rst_alu_ctrl", 32'(bus.o_alu_ctrl), 32'(ALU_ADD));
        checkOutput("rst_alu_stall", 32'(bus.o_alu_stall), 32'd1);
        checkOutput("rst_valid", 32'(bus.o_valid), 32'd0);
        checkOutput("rst_pc", bus.o_pc, 32'h0);
        checkOutput("rst_id_stall", 32'(bus.o_id_stall), 32'd0);
        bus.i_stall = 1'b1;
        settle();
        checkOutput("rst_id_stall_follows_stall", 32'(bus.o_id_stall), 32'd1);
        bus.i_stall = 1'b0;
        rst = 1'b0;

        // ADD x3,x1,x2 with rs data 5/7
        applyStimulus(1'b1, 32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'h0, ALU_ADD, OP1_RS1, OP2_RS2, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("add_op1", bus.o_op1, 32'd5);
        checkOutput("add_op2", bus.o_op2, 32'd7);
        checkOutput("add_valid", 32'(bus.o_valid), 32'd1);
        checkOutput("add_reg_wr", 32'(bus.o_reg_wr), 32'd1);
        checkOutput("add_rd", 32'(bus.o_rd_addr), 32'd3);
        checkOutput("add_pc", bus.o_pc, 32'h100);
        checkOutput("add_alu_stall", 32'(bus.o_alu_stall), 32'd0);

        // SUB x4,x3,x1: rs1 stale in the register file, forwarded from EX/MEM
        applyStimulus(1'b1, 32'h104, 5'd3, 32'h11, 5'd1, 32'd5, 5'd4, 32'h0, ALU_SUB, OP1_RS1, OP2_RS2, 1'b1, 1'b0, 1'b0);
        tick();
        setForward(1'b1, 5'd3, 32'd12, 1'b0, 5'd0, 32'h0);
        settle();
        checkOutput("sub_fwd_exmem_op1", bus.o_op1, 32'd12);
        checkOutput("sub_op2", bus.o_op2, 32'd5);
        checkOutput("sub_alu_ctrl", 32'(bus.o_alu_ctrl), 32'(ALU_SUB));
        setForward(1'b1, 5'd3, 32'd12, 1'b1, 5'd3, 32'd9);
        settle();
        checkOutput("both_hit_exmem_wins", bus.o_op1, 32'd12);
        setForward(1'b0, 5'd3, 32'd12, 1'b1, 5'd3, 32'd9);
        settle();
        checkOutput("memwb_only", bus.o_op1, 32'd9);
        setForward(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        settle();
        checkOutput("no_fwd_stored", bus.o_op1, 32'h11);

        // Instruction reading x0 while both forward sources "write" x0
        applyStimulus(1'b1, 32'h108, 5'd0, 32'h0, 5'd0, 32'h0, 5'd8, 32'h0, ALU_OR, OP1_RS1, OP2_RS2, 1'b1, 1'b0, 1'b0);
        tick();
        setForward(1'b1, 5'd0, 32'd99, 1'b1, 5'd0, 32'd99);
        settle();
        checkOutput("x0_no_fwd_op1", bus.o_op1, 32'h0);
        checkOutput("x0_no_fwd_op2", bus.o_op2, 32'h0);
        setForward(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // PC/imm selects and forwarded store data
        applyStimulus(1'b1, 32'h200, 5'd1, 32'd5, 5'd2, 32'h77, 5'd0, 32'h40, ALU_ADD, OP1_PC, OP2_IMM, 1'b0, 1'b0, 1'b1);
        tick();
        setForward(1'b1, 5'd2, 32'hAB, 1'b0, 5'd0, 32'h0);
        settle();
        checkOutput("sel_op1_pc", bus.o_op1, 32'h200);
        checkOutput("sel_op2_imm", bus.o_op2, 32'h40);
        checkOutput("store_data_fwd", bus.o_store_data, 32'hAB);
        checkOutput("store_mem_wr", 32'(bus.o_mem_wr), 32'd1);
        setForward(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        settle();
        checkOutput("store_data_plain", bus.o_store_data, 32'h77);

        // LW x5 then ADD x6,x5,x1: one-cycle stall, bubble, MEM/WB forward
        applyStimulus(1'b1, 32'h300, 5'd1, 32'd5, 5'd0, 32'h0, 5'd5, 32'd4, ALU_ADD, OP1_RS1, OP2_IMM, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("lw_mem_rd", 32'(bus.o_mem_rd), 32'd1);
        applyStimulus(1'b1, 32'h304, 5'd5, 32'h0, 5'd1, 32'd5, 5'd6, 32'h0, ALU_ADD, OP1_RS1, OP2_RS2, 1'b1, 1'b0, 1'b0);
        settle();
        checkOutput("loaduse_id_stall", 32'(bus.o_id_stall), 32'd1);
        tick();
        checkOutput("loaduse_bubble_valid", 32'(bus.o_valid), 32'd0);
        checkOutput("loaduse_bubble_alu_stall", 32'(bus.o_alu_stall), 32'd1);
        checkOutput("loaduse_bubble_reg_wr", 32'(bus.o_reg_wr), 32'd0);
        checkOutput("loaduse_stall_released", 32'(bus.o_id_stall), 32'd0);
        tick();
        setForward(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234);
        settle();
        checkOutput("loaduse_fwd_memwb", bus.o_op1, 32'h1234);
        checkOutput("loaduse_dep_valid", 32'(bus.o_valid), 32'd1);
        checkOutput("loaduse_dep_rd", 32'(bus.o_rd_addr), 32'd6);
        setForward(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Hold for three cycles while x2 retires through MEM/WB
        applyStimulus(1'b1, 32'h400, 5'd1, 32'd5, 5'd2, 32'h0, 5'd7, 32'h0, ALU_ADD, OP1_RS1, OP2_RS2, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.i_stall = 1'b1;
        settle();
        checkOutput("hold_id_stall", 32'(bus.o_id_stall), 32'd1);
        checkOutput("hold_alu_stall", 32'(bus.o_alu_stall), 32'd1);
        tick();
        setForward(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h55);
        tick();
        setForward(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        checkOutput("hold_valid_kept", 32'(bus.o_valid), 32'd1);
        checkOutput("hold_pc_kept", bus.o_pc, 32'h400);
        bus.i_stall = 1'b0;
        settle();
        checkOutput("hold_refresh_op2", bus.o_op2, 32'h55);
        checkOutput("hold_release_alu_stall", 32'(bus.o_alu_stall), 32'd0);

        // Flush with stall and a load-use pattern
        applyStimulus(1'b1, 32'h500, 5'd1, 32'd5, 5'd0, 32'h0, 5'd5, 32'd4, ALU_ADD, OP1_RS1, OP2_IMM, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h504, 5'd5, 32'h0, 5'd1, 32'd5, 5'd6, 32'h0, ALU_ADD, OP1_RS1, OP2_RS2, 1'b1, 1'b0, 1'b0);
        bus.i_flush = 1'b1;
        bus.i_stall = 1'b1;
        settle();
        checkOutput("flush_id_stall_is_stall", 32'(bus.o_id_stall), 32'd1);
        bus.i_stall = 1'b0;
        settle();
        checkOutput("flush_suppresses_loaduse", 32'(bus.o_id_stall), 32'd0);
        bus.i_stall = 1'b1;
        tick();
        checkOutput("flush_bubble_valid", 32'(bus.o_valid), 32'd0);
        checkOutput("flush_bubble_mem_rd", 32'(bus.o_mem_rd), 32'd0);
        checkOutput("flush_bubble_pc", bus.o_pc, 32'h0);
        checkOutput("flush_bubble_rd", 32'(bus.o_rd_addr), 32'd0);
        bus.i_flush = 1'b0;
        bus.i_stall = 1'b0;
        settle();
        checkOutput("after_flush_no_stall", 32'(bus.o_id_stall), 32'd0);

        // Reset in the middle of a hold
        applyStimulus(1'b1, 32'h600, 5'd1, 32'd5, 5'd2, 32'd7, 5'd9, 32'h0, ALU_XOR, OP1_RS1, OP2_RS2, 1'b1, 1'b0, 1'b0);
        tick();
        bus.i_stall = 1'b1;
        tick();
        checkOutput("prereset_held_pc", bus.o_pc, 32'h600);
        rst = 1'b1;
        tick();
        checkOutput("midstall_rst_valid", 32'(bus.o_valid), 32'd0);
        checkOutput("midstall_rst_pc", bus.o_pc, 32'h0);
        checkOutput("midstall_rst_alu_ctrl", 32'(bus.o_alu_ctrl), 32'(ALU_ADD));
        checkOutput("midstall_rst_alu_stall", 32'(bus.o_alu_stall), 32'd1);
        checkOutput("midstall_rst_id_stall", 32'(bus.o_id_stall), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
